// File: rtl/frec_bcd_display.sv
// frec_bcd_display: converts the binary edge count from the frequency meter to six
// 7-segment digits using a sequential double-dabble (one shift per clock).
// Optional build macro: LEADING_ZERO_BLANK_EN blanks digits above the most significant
// non-zero digit (disp0 always shown). Undefined: all digits zero-padded.
module frec_bcd_display #(
    parameter int unsigned CNT_W   = 20,
    parameter bit          SEG_INV = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [CNT_W-1:0] count,
    input  logic             count_valid,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [6:0]       disp0,
    output logic [6:0]       disp1,
    output logic [6:0]       disp2,
    output logic [6:0]       disp3,
    output logic [6:0]       disp4,
    output logic [6:0]       disp5
);

    localparam int unsigned IW = (CNT_W > 1) ? $clog2(CNT_W) : 1;
    localparam logic [IW-1:0] LAST_ITER = IW'(CNT_W - 1);

    // Active-low segment codes; pol() maps them to the configured polarity.
    localparam logic [6:0] SEG_ZERO  = 7'h40;
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [6:0] SEG_DASH  = 7'h3F;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] SEG_RST_HI = SEG_BLANK;
`else
    localparam logic [6:0] SEG_RST_HI = SEG_ZERO;
`endif

    typedef enum logic [1:0] {StIdle, StShift, StLatch} state_t;

    function automatic logic [6:0] pol(input logic [6:0] al);
        return SEG_INV ? al : ~al;
    endfunction

    function automatic logic [6:0] dec(input logic [3:0] n);
        case (n)
            4'd0:    return 7'h40;
            4'd1:    return 7'h79;
            4'd2:    return 7'h24;
            4'd3:    return 7'h30;
            4'd4:    return 7'h19;
            4'd5:    return 7'h12;
            4'd6:    return 7'h02;
            4'd7:    return 7'h78;
            4'd8:    return 7'h00;
            4'd9:    return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic is_ovf(input logic [CNT_W-1:0] v);
        return 64'(v) > 64'd999999;
    endfunction

    state_t              state;
    logic [CNT_W-1:0]    bin_q;
    logic [23:0]         bcd_q;
    logic [IW-1:0]       iter_q;
    logic                cvt_ovf_q;
    logic                pend_valid_q;
    logic [CNT_W-1:0]    pend_val_q;
    logic [6:0]          disp_q [6];

    logic [23:0]         bcd_adj;
    logic [CNT_W+23:0]   shifted;
    logic [6:0]          disp_new [6];
    logic [3:0]          nib;
    logic                load;
    logic [CNT_W-1:0]    load_val;
`ifdef LEADING_ZERO_BLANK_EN
    logic                nz;
`endif

    assign disp0 = disp_q[0];
    assign disp1 = disp_q[1];
    assign disp2 = disp_q[2];
    assign disp3 = disp_q[3];
    assign disp4 = disp_q[4];
    assign disp5 = disp_q[5];

    // Double-dabble step: add 3 to every nibble >= 5, then shift {bcd,bin} left.
    always_comb begin
        bcd_adj = bcd_q;
        for (int i = 0; i < 6; i++) begin
            if (bcd_q[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
            end
        end
        shifted = {bcd_adj, bin_q} << 1;
    end

    // Segment image for the finished conversion, scanned from the top digit down.
    always_comb begin
        nib = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
        nz = 1'b0;
`endif
        for (int i = 5; i >= 0; i--) begin
            nib = bcd_q[4*i +: 4];
`ifdef LEADING_ZERO_BLANK_EN
            nz = nz | (nib != 4'd0);
            if (cvt_ovf_q) begin
                disp_new[i] = pol(SEG_DASH);
            end else if (i != 0 && !nz) begin
                disp_new[i] = pol(SEG_BLANK);
            end else begin
                disp_new[i] = pol(dec(nib));
            end
`else
            disp_new[i] = cvt_ovf_q ? pol(SEG_DASH) : pol(dec(nib));
`endif
        end
    end

    // Start decision: fresh strobe in idle, or pending/strobe right at the end of a conversion.
    always_comb begin
        load     = 1'b0;
        load_val = count;
        case (state)
            StIdle:  load = count_valid;
            StLatch: begin
                load     = pend_valid_q | count_valid;
                load_val = pend_valid_q ? pend_val_q : count;
            end
            default: load = 1'b0;
        endcase
    end

    // Conversion FSM with registered status and display outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= StIdle;
            bin_q        <= '0;
            bcd_q        <= '0;
            iter_q       <= '0;
            cvt_ovf_q    <= 1'b0;
            pend_valid_q <= 1'b0;
            pend_val_q   <= '0;
            busy         <= 1'b0;
            done         <= 1'b0;
            ovf          <= 1'b0;
            for (int i = 0; i < 6; i++) begin
                disp_q[i] <= pol((i == 0) ? SEG_ZERO : SEG_RST_HI);
            end
        end else begin
            done <= 1'b0;
            case (state)
                StShift: begin
                    bcd_q  <= shifted[CNT_W +: 24];
                    bin_q  <= shifted[CNT_W-1:0];
                    iter_q <= iter_q + 1'b1;
                    if (iter_q == LAST_ITER) begin
                        state <= StLatch;
                    end
                    if (count_valid) begin
                        pend_valid_q <= 1'b1;
                        pend_val_q   <= count;
                    end
                end
                StLatch: begin
                    for (int i = 0; i < 6; i++) begin
                        disp_q[i] <= disp_new[i];
                    end
                    done <= 1'b1;
                    ovf  <= cvt_ovf_q;
                    // A strobe here is queued only if the pending slot is being consumed now.
                    pend_valid_q <= pend_valid_q & count_valid;
                    if (pend_valid_q & count_valid) begin
                        pend_val_q <= count;
                    end
                    if (!load) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: ;
            endcase
            if (load) begin
                state     <= StShift;
                busy      <= 1'b1;
                bin_q     <= load_val;
                bcd_q     <= '0;
                iter_q    <= '0;
                cvt_ovf_q <= is_ovf(load_val);
            end
        end
    end

endmodule

// File: tb/tb_frec_bcd_display.sv
// Self-checking bench for frec_bcd_display: behavioural model (integer digits, conversion
// timeline with one-deep pending slot) compared every cycle, plus literal spot checks.
module tb_frec_bcd_display;

    localparam int CNT_W = 20;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [19:0] count = '0;
    logic        count_valid = 1'b0;
    logic        busy, done, ovf;
    logic [6:0]  disp0, disp1, disp2, disp3, disp4, disp5;
    logic [6:0]  dw [6];

    frec_bcd_display #(.CNT_W(CNT_W), .SEG_INV(1'b1)) dut (
        .clk(clk), .rst(rst), .count(count), .count_valid(count_valid),
        .busy(busy), .done(done), .ovf(ovf),
        .disp0(disp0), .disp1(disp1), .disp2(disp2),
        .disp3(disp3), .disp4(disp4), .disp5(disp5)
    );

    assign dw[0] = disp0; assign dw[1] = disp1; assign dw[2] = disp2;
    assign dw[3] = disp3; assign dw[4] = disp4; assign dw[5] = disp5;

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         k = 0;
    bit         m_active = 0;
    int         m_end = 0;
    int         m_cur = 0;
    bit         m_pend = 0;
    int         m_pend_val = 0;
    logic [6:0] exp_disp [6];
    logic       exp_busy = 0, exp_done = 0, exp_ovf = 0;

    function automatic logic [6:0] seg_of(input int d);
        case (d)
            0: return 7'h40; 1: return 7'h79; 2: return 7'h24; 3: return 7'h30;
            4: return 7'h19; 5: return 7'h12; 6: return 7'h02; 7: return 7'h78;
            8: return 7'h00; default: return 7'h10;
        endcase
    endfunction

    function automatic void show(input int v);
        int p;
        p = 1;
        for (int i = 0; i < 6; i++) begin
            if (v > 999999) begin
                exp_disp[i] = 7'h3F;
            end else begin
                exp_disp[i] = seg_of((v / p) % 10);
`ifdef LEADING_ZERO_BLANK_EN
                if (i > 0 && v < p) exp_disp[i] = 7'h7F;
`endif
            end
            p = p * 10;
        end
        exp_ovf = (v > 999999);
    endfunction

    function automatic void start(input int v);
        m_active = 1;
        m_cur    = v;
        m_end    = k + CNT_W + 1;
    endfunction

    function automatic void model_step(input logic r, input logic cv, input int val);
        exp_done = 0;
        if (!r) begin
            m_active = 0; m_pend = 0; exp_ovf = 0;
            exp_disp[0] = 7'h40;
            for (int i = 1; i < 6; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
                exp_disp[i] = 7'h7F;
`else
                exp_disp[i] = 7'h40;
`endif
            end
        end else begin
            if (m_active && k == m_end) begin
                show(m_cur);
                exp_done = 1;
                m_active = 0;
                if (m_pend) start(m_pend_val);
                m_pend = 0;
            end
            if (cv) begin
                if (m_active) begin
                    m_pend = 1;
                    m_pend_val = val;
                end else begin
                    start(val);
                end
            end
        end
        exp_busy = m_active;
    endfunction

    // Compare process: model advances on each edge, DUT checked 1 time unit later.
    always @(posedge clk) begin
        logic r, cv;
        int   val;
        r = rst; cv = count_valid; val = int'(count);
        k++;
        model_step(r, cv, val);
        #1;
        chk("busy", busy, exp_busy);
        chk("done", done, exp_done);
        chk("ovf", ovf, exp_ovf);
        for (int i = 0; i < 6; i++) chk($sformatf("disp%0d", i), dw[i], exp_disp[i]);
        if (done === 1'b1) done_cnt++;
    end

    // ---------------- stimulus ----------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input int v);
        @(negedge clk);
        count = 20'(v);
        count_valid = 1'b1;
        @(negedge clk);
        count_valid = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #2;
            n++;
            if (done === 1'b1) break;
        end
        if (done !== 1'b1) n = 999;
    endtask

    initial begin
        int n, d0, kind, v;
        idle(3);
        rst = 1'b1;
        idle(2);
        chk("rst_disp0", disp0, 7'h40);
`ifdef LEADING_ZERO_BLANK_EN
        chk("rst_disp5", disp5, 7'h7F);
`else
        chk("rst_disp5", disp5, 7'h40);
`endif
        chk("rst_busy", busy, 0);
        chk("rst_ovf", ovf, 0);

        pulse(123456);
        wait_done(n);
        chk("lat123456", n, CNT_W + 1);
        chk("busy_after", busy, 0);
        chk("d5_123456", disp5, 7'h79);
        chk("d4_123456", disp4, 7'h24);
        chk("d3_123456", disp3, 7'h30);
        chk("d2_123456", disp2, 7'h19);
        chk("d1_123456", disp1, 7'h12);
        chk("d0_123456", disp0, 7'h02);

        pulse(999999);
        wait_done(n);
        chk("d5_999999", disp5, 7'h10);
        chk("d0_999999", disp0, 7'h10);
        chk("ovf_999999", ovf, 0);
        pulse(1000000);
        wait_done(n);
        chk("d5_ovf", disp5, 7'h3F);
        chk("d0_ovf", disp0, 7'h3F);
        chk("ovf_1000000", ovf, 1);

`ifdef LEADING_ZERO_BLANK_EN
        pulse(100000);
        wait_done(n);
        chk("d5_100000", disp5, 7'h79);
        chk("d4_100000", disp4, 7'h40);
        chk("d0_100000", disp0, 7'h40);
        pulse(50);
        wait_done(n);
        chk("d5_50", disp5, 7'h7F);
        chk("d2_50", disp2, 7'h7F);
        chk("d1_50", disp1, 7'h12);
        chk("d0_50", disp0, 7'h40);
`endif

        // Overwrite of pending while busy: 111111 then 333333.
        d0 = done_cnt;
        pulse(111111);
        idle(3);
        pulse(222222);
        idle(2);
        pulse(333333);
        wait_done(n);
        chk("d5_111111", disp5, 7'h79);
        wait_done(n);
        chk("d0_333333", disp0, 7'h30);
        idle(30);
        chk("dones_b2b", done_cnt - d0, 2);

        // Strobe landing exactly on the latch cycle.
        d0 = done_cnt;
        pulse(7);
        idle(CNT_W - 1);
        pulse(8);
        wait_done(n);
        chk("d0_8", disp0, 7'h00);
        chk("dones_latch", done_cnt - d0, 2);

        // Reset during conversion aborts it.
        pulse(654321);
        idle(9);
        d0 = done_cnt;
        rst = 1'b0;
        idle(2);
        rst = 1'b1;
        idle(30);
        chk("no_done_rst", done_cnt - d0, 0);
        chk("rst2_disp0", disp0, 7'h40);
        chk("rst2_busy", busy, 0);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            kind = int'($urandom_range(0, 5));
            case (kind)
                0: v = int'($urandom_range(0, 999999));
                1: v = 0;
                2: v = 999999;
                3: v = 1000000;
                4: v = int'($urandom_range(0, 1048575));
                default: v = int'($urandom_range(0, 99));
            endcase
            count = 20'(v);
            count_valid = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 599) != 0);
        end
        @(negedge clk);
        count_valid = 1'b0;
        rst = 1'b1;
        idle(60);
        chk("idle_end", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
